// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : IF/DM request ports and single-port memory bus of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        if_stall_o;

  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_valid_o;
  logic        dm_stall_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  logic        bus_err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_valid_o, if_stall_o,
    output dm_rdata_o, dm_valid_o, dm_stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output bus_err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_valid_o, if_stall_o,
    input  dm_rdata_o, dm_valid_o, dm_stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  bus_err_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between fetch and data stages,
//            with a DM-streak limit and a per-access timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT       = 16
) (
  input  wire logic         clk_i,
  input  wire logic         reset_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0]  c_max_streak = 4'(MAX_DM_STREAK);
  localparam logic [7:0]  c_wait_last  = 8'(TIMEOUT - 1);
  localparam logic [31:0] c_if_nop     = 32'h0000_0013;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_streak;
  logic [7:0]  r_wait;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_bus_err;

  logic        w_grant_if;
  logic        w_grant_dm;
  logic        w_busy;
  logic        w_done;
  logic        w_timeout;
  logic        w_if_valid;
  logic        w_dm_valid;

  // Arbitration only happens in IDLE; DM wins ties unless IF has been
  // passed over MAX_DM_STREAK times in a row.
  always_comb begin
    w_state_next = r_state;
    w_grant_if   = 1'b0;
    w_grant_dm   = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.dm_req_i && !(bus.if_req_i && (r_streak == c_max_streak))) begin
          w_grant_dm   = 1'b1;
          w_state_next = ST_BUSY_DM;
        end else if (bus.if_req_i) begin
          w_grant_if   = 1'b1;
          w_state_next = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        w_busy    = 1'b1;
        w_timeout = !bus.mem_ack_i && (r_wait == c_wait_last);
        w_done    = bus.mem_ack_i || w_timeout;
        if (w_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_we    <= 1'b0;
    end else if (w_grant_dm) begin
      r_addr  <= bus.dm_addr_i;
      r_wdata <= bus.dm_wdata_i;
      r_we    <= bus.dm_we_i;
    end else if (w_grant_if) begin
      r_addr  <= bus.if_addr_i;
      r_wdata <= 32'h0;
      r_we    <= 1'b0;
    end
  end

  // Counts DM wins that left a fetch waiting; saturates at the limit.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_streak <= 4'h0;
    end else if (w_grant_if) begin
      r_streak <= 4'h0;
    end else if (w_grant_dm) begin
      if (!bus.if_req_i) begin
        r_streak <= 4'h0;
      end else if (r_streak != c_max_streak) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wait <= 8'h0;
    end else if (w_grant_if || w_grant_dm) begin
      r_wait <= 8'h0;
    end else if (w_busy && !w_done) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end
  end

  assign w_if_valid = (r_state == ST_BUSY_IF) && w_done;
  assign w_dm_valid = (r_state == ST_BUSY_DM) && w_done;

  // A timed-out fetch returns a NOP so the pipeline keeps flowing.
  assign bus.if_rdata_o = !w_if_valid ? 32'h0 :
                          (w_timeout ? c_if_nop : bus.mem_rdata_i);
  assign bus.dm_rdata_o = (w_dm_valid && !w_timeout) ? bus.mem_rdata_i : 32'h0;
  assign bus.if_valid_o = w_if_valid;
  assign bus.dm_valid_o = w_dm_valid;
  assign bus.if_stall_o = reset_i && bus.if_req_i && !w_if_valid;
  assign bus.dm_stall_o = reset_i && bus.dm_req_i && !w_dm_valid;

  assign bus.mem_req_o   = w_busy;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.bus_err_o   = r_bus_err;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port unified memory between the instruction-fetch stage (IF port) and the data-memory stage (DM port) of the 5-stage core.
- Captures the winning request and holds it on the memory side until the memory acknowledges.
- Returns read data and a one-cycle valid to the winner, and stalls the loser.
- Sits between the processor and the memory, beside the top-level datapath.

Parameters:
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF waits before IF is forced to win (1..15).
- TIMEOUT, 16, cycles in a BUSY state without mem_ack_i before the access is aborted (2..255).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held until if_valid_o.
- if_addr_i  in  32  fetch address.
- if_rdata_o  out  32  fetch data; valid only when if_valid_o=1.
- if_valid_o  out  1  one-cycle fetch completion.
- if_stall_o  out  1  if_req_i & ~if_valid_o.
- dm_req_i  in  1  data request; held until dm_valid_o.
- dm_we_i  in  1  1=store, 0=load.
- dm_addr_i  in  32  data address.
- dm_wdata_i  in  32  store data.
- dm_rdata_o  out  32  load data; valid only when dm_valid_o=1.
- dm_valid_o  out  1  one-cycle data completion (loads and stores).
- dm_stall_o  out  1  dm_req_i & ~dm_valid_o.
- mem_req_o  out  1  memory request, high throughout BUSY_IF/BUSY_DM.
- mem_we_o  out  1  memory write enable; 0 for IF.
- mem_addr_o  out  32  captured address.
- mem_wdata_o  out  32  captured store data; 0 for IF.
- mem_rdata_i  in  32  memory read data, sampled with mem_ack_i.
- mem_ack_i  in  1  memory completion; ignored when mem_req_o=0.
- bus_err_o  out  1  sticky timeout flag.

Behaviour:
Reset (reset_i=0, asynchronous):
- State goes to IDLE and streak_cnt to 0.
- Captured addr, wdata and we go to 0; bus_err_o goes to 0.
- All outputs are 0 while in reset, including mem_req_o and both valids.
- Reset mid-access drops mem_req_o immediately; no valid is issued for the aborted access.

States: IDLE, BUSY_IF, BUSY_DM.

IDLE:
- Requests are evaluated only here.
- Only dm_req_i: go to BUSY_DM.
- Only if_req_i: go to BUSY_IF.
- Both: BUSY_IF if streak_cnt==MAX_DM_STREAK, else BUSY_DM (DM priority avoids pipeline deadlock).
- Neither: stay in IDLE.
- On grant, capture the winner's addr (and for DM, wdata and we) into registers. mem_* outputs drive from these registers only.

BUSY_x:
- mem_req_o=1.
- On mem_ack_i=1:
  - x_valid_o=1 that same cycle (combinational on state & ack).
  - x_rdata_o = mem_rdata_i, passed through.
  - Next state is IDLE.
- Minimum access is 3 cycles: IDLE (grant) → BUSY (ack) → IDLE. A requester holding req through its valid cycle cannot be double-granted, because IDLE follows every completion.

Streak counter (saturating at MAX_DM_STREAK):
- DM grant while if_req_i=1: increment.
- DM grant while if_req_i=0: clear to 0.
- Any IF grant: clear to 0.

Timeout:
- wait_cnt clears on entry to BUSY and increments each BUSY cycle without ack.
- At wait_cnt==TIMEOUT-1 with no ack:
  - x_valid_o=1 with x_rdata_o=32'h0000_0013 for IF (NOP) or 0 for DM.
  - bus_err_o is set (sticky until reset).
  - Next state is IDLE.
- Ack in the same cycle as timeout: treated as a normal ack, bus_err_o unchanged.

Other rules:
- A requester may not change addr/we/wdata while stalled; the arbiter uses the captured copies regardless.
- Valid outputs are never high outside the winner's BUSY state.
- if_valid_o and dm_valid_o are never high together.

Test Plan:
- Reset: hold reset_i=0 mid BUSY_DM with mem_ack_i toggling → mem_req_o=0 and both valids 0 asynchronously; after release, state is IDLE and bus_err_o=0.
- Single IF: if_req_i=1, addr=0x100; memory acks 2 cycles after mem_req_o → mem_addr_o=0x100, mem_we_o=0, if_valid_o pulses once with if_rdata_o=mem_rdata_i=0x00500093; if_stall_o=1 until then.
- Collision: if_req_i=dm_req_i=1 (dm store, addr 0x2000, wdata 0xDEADBEEF) in IDLE, zero-wait ack → DM granted first with mem_we_o=1 and mem_wdata_o=0xDEADBEEF; IF granted on the following IDLE.
- Starvation: if_req_i held at 1, dm_req_i re-raised every IDLE, MAX_DM_STREAK=4 → exactly 4 DM grants, then 1 IF grant, then DM resumes with streak_cnt=1 after its next grant.
- Timeout: DM load, mem_ack_i never asserted, TIMEOUT=16 → dm_valid_o on the 16th BUSY cycle with dm_rdata_o=0; bus_err_o=1 and stays 1; the next IF access completes normally.
- Ack on the timeout cycle: mem_ack_i arrives on cycle 16, rdata 0x1234 → dm_rdata_o=0x1234, bus_err_o stays 0.
